// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, operand width, instruction fields, issuer states.
// Pure declarations: no latency and no backpressure.
package alu_pkg;

    localparam int ALU_W     = 32;
    localparam int REG_IDX_W = 3;
    localparam int INSTR_W   = 16;

    // Instruction field positions (3-bit fields, low 4 bits unused).
    localparam int OP_LSB  = 13;
    localparam int RD_LSB  = 10;
    localparam int RS1_LSB = 7;
    localparam int RS2_LSB = 4;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_ADD     = 3'd1,
        OP_SUB     = 3'd2,
        OP_AND     = 3'd3,
        OP_OR      = 3'd4,
        OP_XOR     = 3'd5,
        OP_NOT     = 3'd6,
        OP_ILLEGAL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } issue_state_e;

    typedef struct packed {
        alu_op_e                op;
        logic [REG_IDX_W-1:0]   rd;
        logic [REG_IDX_W-1:0]   rs1;
        logic [REG_IDX_W-1:0]   rs2;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        instr_t d;
        d.op  = alu_op_e'(raw[OP_LSB +: 3]);
        d.rd  = raw[RD_LSB  +: REG_IDX_W];
        d.rs1 = raw[RS1_LSB +: REG_IDX_W];
        d.rs2 = raw[RS2_LSB +: REG_IDX_W];
        return d;
    endfunction

    function automatic logic op_has_carry(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU; result[32] is carry for ADD and borrow for SUB.
// Zero latency, no backpressure; output forced to 0 when disabled.
module alu
    import alu_pkg::*;
(
    input  logic [2:0]       opcode,
    input  logic [ALU_W-1:0] op1,
    input  logic [ALU_W-1:0] op2,
    input  logic             en,
    output logic [ALU_W:0]   result,
    output logic             overflow
);

    logic [ALU_W:0] ext1;
    logic [ALU_W:0] ext2;

    assign ext1 = {1'b0, op1};
    assign ext2 = {1'b0, op2};

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        if (en) begin
            case (alu_op_e'(opcode))
                OP_ADD: begin
                    result   = ext1 + ext2;
                    overflow = (op1[ALU_W-1] == op2[ALU_W-1]) &&
                               (result[ALU_W-1] != op1[ALU_W-1]);
                end
                OP_SUB: begin
                    result   = ext1 - ext2;
                    overflow = (op1[ALU_W-1] != op2[ALU_W-1]) &&
                               (result[ALU_W-1] != op1[ALU_W-1]);
                end
                OP_AND:  result = ext1 & ext2;
                OP_OR:   result = ext1 | ext2;
                OP_XOR:  result = ext1 ^ ext2;
                OP_NOT:  result = {1'b0, ~op1};
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file, two combinational read ports, load and writeback ports.
// Writes land at the next edge; writeback overrides a same-cycle load to the same index.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_W,
    parameter int NREGS  = 8,
    parameter int AW     = REG_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [AW-1:0]     rd_addr1,
    input  logic [AW-1:0]     rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (ld_en) begin
            rf_d[ld_addr] = ld_data;
        end
        // Applied last so the ALU result beats an external load.
        if (wb_en) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= rst ? '0 : rf_d[i];
        end
    end

    assign rd_data1 = rf_q[rd_addr1];
    assign rd_data2 = rf_q[rd_addr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one register-format instruction at a time to the ALU and returns its result.
// Accept->res_valid is 2 cycles; instr_ready is low until the result handshake completes.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_W,
    parameter int NREGS  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    input  logic [INSTR_W-1:0]   instr,
    output logic                 instr_ready,
    input  logic                 ld_en,
    input  logic [REG_IDX_W-1:0] ld_addr,
    input  logic [DATA_W-1:0]    ld_data,
    output logic [2:0]           alu_opcode,
    output logic [DATA_W-1:0]    alu_op1,
    output logic [DATA_W-1:0]    alu_op2,
    output logic                 alu_en,
    input  logic [DATA_W:0]      alu_result,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DATA_W-1:0]    res_data,
    output logic                 res_carry,
    output logic [REG_IDX_W-1:0] res_rd,
    output logic                 err_illegal,
    output logic [CNT_W-1:0]     op_count
);

    issue_state_e state_q, state_d;

    instr_t                 ins_q, ins_d;
    instr_t                 dec;
    logic [DATA_W-1:0]      res_data_q, res_data_d;
    logic                   res_carry_q, res_carry_d;
    logic [REG_IDX_W-1:0]   res_rd_q, res_rd_d;
    logic [CNT_W-1:0]       op_count_q, op_count_d;
    logic                   err_illegal_q, err_illegal_d;

    logic                   instr_hs;
    logic                   res_hs;
    logic [DATA_W-1:0]      rf_rd1;
    logic [DATA_W-1:0]      rf_rd2;

    assign dec      = decode_instr(instr);
    assign instr_hs = instr_valid && instr_ready;
    assign res_hs   = res_valid && res_ready;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (REG_IDX_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .wb_en    (res_hs),
        .wb_addr  (res_rd_q),
        .wb_data  (res_data_q),
        .rd_addr1 (ins_q.rs1),
        .rd_addr2 (ins_q.rs2),
        .rd_data1 (rf_rd1),
        .rd_data2 (rf_rd2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // NOP and illegal opcodes retire in IDLE without touching the ALU.
                if (instr_hs && (dec.op != OP_NOP) && (dec.op != OP_ILLEGAL)) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP: begin
                if (res_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        alu_en      = 1'b0;
        alu_opcode  = 3'd0;
        alu_op1     = '0;
        alu_op2     = '0;
        res_valid   = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: instr_ready = 1'b1;
                ST_ISSUE: begin
                    alu_en     = 1'b1;
                    alu_opcode = ins_q.op;
                    alu_op1    = rf_rd1;
                    alu_op2    = (ins_q.op == OP_NOT) ? '0 : rf_rd2;
                end
                ST_RESP: res_valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        ins_d         = ins_q;
        res_data_d    = res_data_q;
        res_carry_d   = res_carry_q;
        res_rd_d      = res_rd_q;
        op_count_d    = op_count_q;
        err_illegal_d = err_illegal_q;

        if (instr_hs) begin
            ins_d = dec;
            if (dec.op == OP_ILLEGAL) begin
                err_illegal_d = 1'b1;
            end
        end

        if (state_q == ST_ISSUE) begin
            res_data_d  = alu_result[DATA_W-1:0];
            res_carry_d = op_has_carry(ins_q.op) ? alu_result[DATA_W] : 1'b0;
            res_rd_d    = ins_q.rd;
        end

        // A NOP accept and a result handshake are in different states, never both.
        if ((instr_hs && (dec.op == OP_NOP)) || res_hs) begin
            op_count_d = op_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ins_q         <= '0;
            res_data_q    <= '0;
            res_carry_q   <= 1'b0;
            res_rd_q      <= '0;
            op_count_q    <= '0;
            err_illegal_q <= 1'b0;
        end else begin
            ins_q         <= ins_d;
            res_data_q    <= res_data_d;
            res_carry_q   <= res_carry_d;
            res_rd_q      <= res_rd_d;
            op_count_q    <= op_count_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign res_data    = res_data_q;
    assign res_carry   = res_carry_q;
    assign res_rd      = res_rd_q;
    assign err_illegal = err_illegal_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with the ALU attached; results go through a scoreboard queue.
// Reference model works on whole instructions with plain 64-bit arithmetic.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic        alu_en;
    logic [32:0] alu_result;
    logic        alu_ovf;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_carry;
    logic [2:0]  res_rd;
    logic        err_illegal;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(32), .NREGS(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_en(alu_en), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_rd(res_rd),
        .err_illegal(err_illegal), .op_count(op_count)
    );

    alu u_alu (
        .opcode(alu_opcode), .op1(alu_op1), .op2(alu_op2), .en(alu_en),
        .result(alu_result), .overflow(alu_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        carry;
        logic [2:0]  rd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_rf [8];
    int unsigned m_cnt;
    bit          m_err;

    function automatic exp_t ref_op(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [2:0] rd);
        exp_t         e;
        longint       x;
        longint       y;
        x       = longint'(a);
        y       = longint'(b);
        e.rd    = rd;
        e.carry = 1'b0;
        case (op)
            3'd1: begin
                e.data  = 32'(x + y);
                e.carry = (x + y) > 64'h0000_0000_FFFF_FFFF;
            end
            3'd2: begin
                e.data  = 32'(x - y);
                e.carry = x < y;
            end
            3'd3:    e.data = a & b;
            3'd4:    e.data = a | b;
            3'd5:    e.data = a ^ b;
            default: e.data = ~a;
        endcase
        return e;
    endfunction

    // Monitor: a result handshake happens at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("res_data", res_data, e.data);
                check("res_carry", res_carry, e.carry);
                check("res_rd", res_rd, e.rd);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_instr_ready"}, instr_ready, 0);
        check({tag, "_alu_en"}, alu_en, 0);
        check({tag, "_alu_opcode"}, alu_opcode, 0);
        check({tag, "_alu_op1"}, alu_op1, 0);
        check({tag, "_alu_op2"}, alu_op2, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_res_carry"}, res_carry, 0);
        check({tag, "_res_rd"}, res_rd, 0);
        check({tag, "_err_illegal"}, err_illegal, 0);
        check({tag, "_op_count"}, op_count, 0);
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        cyc();
        m_rf[a] = d;
        ld_en   = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input int hold, input bit ld_issue,
                         input bit ld_wb, input bit rst_issue);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        check("instr_ready_idle", instr_ready, 1);
        instr_valid = 1'b1;
        instr       = {op, rd, rs1, rs2, 4'($urandom)};
        cyc();
        instr_valid = 1'b0;
        if (op == 3'd0) begin
            m_cnt++;
            check("nop_op_count", op_count, 64'(m_cnt[15:0]));
            check("nop_res_valid", res_valid, 0);
            check("nop_instr_ready", instr_ready, 1);
            return;
        end
        if (op == 3'd7) begin
            m_err = 1'b1;
            check("ill_err", err_illegal, 1);
            check("ill_op_count", op_count, 64'(m_cnt[15:0]));
            check("ill_instr_ready", instr_ready, 1);
            check("ill_alu_en", alu_en, 0);
            return;
        end
        a = m_rf[rs1];
        b = (op == 3'd6) ? 32'd0 : m_rf[rs2];
        check("issue_alu_en", alu_en, 1);
        check("issue_alu_opcode", alu_opcode, op);
        check("issue_alu_op1", alu_op1, a);
        check("issue_alu_op2", alu_op2, b);
        check("issue_instr_ready", instr_ready, 0);
        check("issue_res_valid", res_valid, 0);
        if (rst_issue) begin
            rst = 1'b1;
            cyc();
            check_all_zero("rst_issue");
            rst = 1'b0;
            for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
            m_cnt = 0;
            m_err = 1'b0;
            cyc();
            check("post_rst_instr_ready", instr_ready, 1);
            check("post_rst_res_valid", res_valid, 0);
            return;
        end
        e = ref_op(op, a, b, rd);
        sb.push_back(e);
        instr_valid = 1'b1;
        if (ld_issue) begin
            ld_en   = 1'b1;
            ld_addr = rs1;
            ld_data = $urandom;
        end
        cyc();
        if (ld_issue) begin
            m_rf[ld_addr] = ld_data;
            ld_en         = 1'b0;
        end
        check("resp_res_valid", res_valid, 1);
        check("resp_alu_en", alu_en, 0);
        check("resp_alu_opcode", alu_opcode, 0);
        check("resp_alu_ops", {alu_op1, alu_op2}, 0);
        check("resp_instr_ready", instr_ready, 0);
        for (int i = 0; i < hold; i++) begin
            cyc();
            check("hold_res_valid", res_valid, 1);
            check("hold_res_data", res_data, e.data);
            check("hold_res_rd", res_rd, e.rd);
            check("hold_instr_ready", instr_ready, 0);
            check("hold_alu_en", alu_en, 0);
        end
        instr_valid = 1'b0;
        res_ready   = 1'b1;
        if (ld_wb) begin
            ld_en   = 1'b1;
            ld_addr = e.rd;
            ld_data = 32'hDEAD_BEEF;
        end
        cyc();
        m_rf[e.rd] = e.data;
        m_cnt++;
        res_ready = 1'b0;
        ld_en     = 1'b0;
        check("wb_res_valid", res_valid, 0);
        check("wb_instr_ready", instr_ready, 1);
        check("wb_op_count", op_count, 64'(m_cnt[15:0]));
    endtask

    initial begin
        logic [2:0] rop;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        res_ready   = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
        m_cnt = 0;
        m_err = 1'b0;
        repeat (3) cyc();
        check_all_zero("reset");
        rst = 1'b0;
        cyc();
        check("reset_release_ready", instr_ready, 1);

        load(3'd1, 32'h0000_0005);
        load(3'd2, 32'h0000_0003);
        do_op(3'd1, 3'd3, 3'd1, 3'd2, 0, 0, 0, 0);
        do_op(3'd1, 3'd7, 3'd3, 3'd0, 0, 0, 0, 0);

        load(3'd1, 32'hFFFF_FFFF);
        load(3'd2, 32'h0000_0001);
        do_op(3'd1, 3'd3, 3'd1, 3'd2, 0, 0, 0, 0);
        do_op(3'd2, 3'd4, 3'd2, 3'd1, 0, 0, 0, 0);

        load(3'd5, 32'hF0F0_F0F0);
        do_op(3'd6, 3'd6, 3'd5, 3'd1, 0, 0, 0, 0);
        do_op(3'd5, 3'd6, 3'd6, 3'd5, 0, 0, 0, 0);

        do_op(3'd3, 3'd7, 3'd6, 3'd5, 5, 0, 0, 0);

        do_op(3'd0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0);
        do_op(3'd7, 3'd1, 3'd2, 3'd3, 0, 0, 0, 0);
        do_op(3'd0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0);
        check("err_sticky", err_illegal, 1);

        do_op(3'd1, 3'd2, 3'd1, 3'd5, 0, 1, 0, 0);
        do_op(3'd4, 3'd3, 3'd1, 3'd2, 1, 0, 1, 0);
        do_op(3'd1, 3'd0, 3'd3, 3'd3, 0, 0, 0, 0);

        do_op(3'd2, 3'd5, 3'd1, 3'd2, 0, 0, 0, 1);
        do_op(3'd4, 3'd3, 3'd1, 3'd5, 0, 0, 0, 0);

        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                load(3'($urandom), $urandom);
            end
            rop = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            do_op(rop, 3'($urandom), 3'($urandom), 3'($urandom), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b0);
            check("rand_err", err_illegal, m_err);
        end

        cyc();
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Instruction-issue front end that drives the 32-bit ALU's opcode, operand and enable inputs and collects its 33-bit result.
- Accepts 16-bit register-format instructions over a valid/ready handshake.
- Reads operands from an internal register file and sequences one ALU operation at a time.
- Returns the result, carry/borrow and destination over a valid/ready result stream, then writes the result back.

Parameters:
DATA_W, 32, operand width; fixed to the ALU width (the result is DATA_W+1 bits).
NREGS, 8, register file depth; the register index is 3 bits.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
instr_valid  in  1  instruction offered
instr  in  16  [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ignored
instr_ready  out  1  issuer can accept an instruction
ld_en  in  1  external register load strobe
ld_addr  in  3  load target register
ld_data  in  DATA_W  load value
alu_opcode  out  3  to ALU: NOP=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 NOT=6
alu_op1  out  DATA_W  to ALU operand1
alu_op2  out  DATA_W  to ALU operand2
alu_en  out  1  to ALU enable
alu_result  in  DATA_W+1  from ALU (combinational)
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  DATA_W  result[31:0]
res_carry  out  1  alu_result[32] for ADD/SUB, 0 otherwise
res_rd  out  3  destination register
err_illegal  out  1  sticky flag: opcode 7 was received
op_count  out  CNT_W  number of completed instructions

Behaviour:
- Reset (synchronous): every output is 0.
  - The state machine goes to IDLE; rf[0..7], op_count and err_illegal are cleared.
  - Reset mid-operation abandons the in-flight instruction with no writeback.
- The ALU overflow output is not used. Carry is taken only from alu_result[32].
- States are IDLE, ISSUE and RESP.
- IDLE:
  - instr_ready=1; alu_en=0; alu_opcode=0; alu_op1 and alu_op2 are 0.
  - A handshake occurs when instr_valid=1 and instr_ready=1; op, rd, rs1 and rs2 are then latched.
  - op=0 (NOP): op_count+1, stay in IDLE, no result is produced.
  - op=7: err_illegal is set (sticky until reset), op_count is unchanged, stay in IDLE.
  - Any other op: go to ISSUE.
- ISSUE (exactly 1 cycle):
  - instr_ready=0; alu_en=1; alu_opcode=latched op.
  - alu_op1=rf[rs1]; alu_op2=rf[rs2], except alu_op2=0 for NOT.
  - At the end of the cycle, alu_result is registered into res_data/res_carry and rd into res_rd. Go to RESP.
- RESP:
  - res_valid=1. res_data, res_carry and res_rd stay stable until the handshake.
  - alu_en=0; alu_opcode and operands return to 0.
  - On res_valid=1 and res_ready=1: rf[rd] <= res_data, op_count+1, res_valid drops next cycle, go to IDLE.
- Latency: instruction accepted at edge T gives res_valid high from T+2. Best-case throughput is one instruction per 3 cycles.
- Operands are read in ISSUE, so an instruction issued immediately after a writeback sees the new value.
- ld_en is accepted in any state.
  - If ld_en and a writeback target the same register in the same cycle, the writeback wins.
  - A load during ISSUE to rs1 or rs2 is not seen by that operation, because the operand uses the pre-edge value.
- SUB carry is the ALU's bit 32, i.e. borrow: 1 when op1 < op2 unsigned.
- op_count wraps from 2^CNT_W-1 to 0 without any flag.

Decomposition:
- Shared package alu_pkg: opcode constants (NOP..NOT, ILLEGAL=7), DATA_W, instruction field bit positions, state encoding.
  - The ALU is updated to use alu_pkg as well.
- One natural sub-module: alu_regfile (NREGS x DATA_W, two combinational read ports, one write port with writeback-over-load priority).

Test Plan:
1. Load r1=0x0000_0005 and r2=0x0000_0003; ADD r3,r1,r2 -> res_valid at T+2, res_data=0x8, carry=0, rd=3; after handshake rf[3]=0x8, op_count=1.
2. Load r1=0xFFFF_FFFF and r2=0x1; ADD -> res_data=0x0, carry=1. SUB r4,r2,r1 -> res_data=0x2, carry=1 (borrow).
3. Set r5=0xF0F0_F0F0; NOT r6,r5 -> alu_op2=0, res_data=0x0F0F_0F0F, carry=0. XOR r6,r6,r5 -> 0xFFFF_FFFF.
4. Hold res_ready=0 for 5 cycles in RESP -> res_* stable, instr_ready=0, alu_en=0; a new instr_valid is not accepted.
5. NOP gives op_count+1 and no res_valid. Opcode 7 gives err_illegal=1 (stays 1), op_count unchanged, instr_ready stays 1.
6. In the writeback cycle, ld_en to the same rd with 0xDEAD_BEEF -> rf[rd]=result. Assert rst during ISSUE -> next cycle all outputs 0, state IDLE, rf cleared.
